// File: rtl/mips_pkg.sv
// mips_pkg: arbiter state encoding and default bus widths shared by the memory port arbiter files.
package mips_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} arb_state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if import mips_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              stall_f;
  logic              stall_m;
  logic              err_spurious;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m, err_spurious
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m, err_spurious
  );
endinterface

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: wrapping 32-bit counters of arbitration conflicts and per-port wait cycles.
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_conflict,
  input  logic        i_stall_f,
  input  logic        i_stall_m,
  output logic [31:0] o_cnt_conflict,
  output logic [31:0] o_cnt_if_wait,
  output logic [31:0] o_cnt_dm_wait
);
  logic [31:0] r_conflict, r_if_wait, r_dm_wait;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= '0;
      r_if_wait  <= '0;
      r_dm_wait  <= '0;
    end else begin
      r_conflict <= r_conflict + {31'd0, i_conflict};
      r_if_wait  <= r_if_wait + {31'd0, i_stall_f};
      r_dm_wait  <= r_dm_wait + {31'd0, i_stall_m};
    end
  end
  assign o_cnt_conflict = r_conflict;
  assign o_cnt_if_wait  = r_if_wait;
  assign o_cnt_dm_wait  = r_dm_wait;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages, data side first.
// Defining MEM_ARB_PERF_EN adds the cnt_conflict/cnt_if_wait/cnt_dm_wait counter ports.
module mem_port_arbiter import mips_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic        clk,
  input  logic        reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] cnt_conflict,
  output logic [31:0] cnt_if_wait,
  output logic [31:0] cnt_dm_wait
`endif
);
  arb_state_t        r_state;
  logic              r_mem_en, r_mem_we, r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_hold, r_dm_hold;
  logic              w_if_ready, w_dm_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_hold   <= '0;
      r_dm_hold   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mem_valid) r_err <= 1'b1;
          if (bus.dm_req) begin
            r_state     <= BUSY_D;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
          end else if (bus.if_req) begin
            r_state    <= BUSY_I;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr;
          end
        end
        BUSY_I: if (bus.mem_valid) begin
          r_if_hold <= bus.mem_rdata;
          r_state   <= IDLE;
        end
        BUSY_D: if (bus.mem_valid) begin
          // a store acknowledge carries no load data, so the hold value survives it
          if (!r_mem_we) r_dm_hold <= bus.mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_if_ready       = ~reset & bus.mem_valid & (r_state == BUSY_I);
  assign w_dm_ready       = ~reset & bus.mem_valid & (r_state == BUSY_D);
  assign bus.if_ready     = w_if_ready;
  assign bus.dm_ready     = w_dm_ready;
  assign bus.if_rdata     = w_if_ready ? bus.mem_rdata : r_if_hold;
  assign bus.dm_rdata     = (w_dm_ready & ~r_mem_we) ? bus.mem_rdata : r_dm_hold;
  assign bus.stall_f      = bus.if_req & ~w_if_ready;
  assign bus.stall_m      = bus.dm_req & ~w_dm_ready;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.err_spurious = r_err;
`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_conflict     ((r_state == IDLE) & bus.if_req & bus.dm_req),
    .i_stall_f      (bus.stall_f),
    .i_stall_m      (bus.stall_m),
    .o_cnt_conflict (cnt_conflict),
    .o_cnt_if_wait  (cnt_if_wait),
    .o_cnt_dm_wait  (cnt_dm_wait)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: per-cycle directed vector table plus a held-request issue-period sequence.
module tb_mem_port_arbiter;
  localparam logic [31:0] IA  = 32'h0040_0000, IA2 = 32'h0040_0004, IA3 = 32'h0040_0008;
  localparam logic [31:0] DA  = 32'h1001_0000, SA  = 32'h1001_0008;
  localparam logic [31:0] DA4 = 32'h1001_0010, DA5 = 32'h1001_0014, DB = 32'hDEAD_BEEF;
  localparam logic [31:0] I1  = 32'h8C08_0004, I2  = 32'h2009_0001, I3 = 32'hCCCC_0003;
  localparam logic [31:0] D1  = 32'h1122_3344, D2  = 32'hAAAA_0001, D3 = 32'hBBBB_0002;
  typedef struct {
    logic rst, ifr; logic [31:0] ifa;
    logic dmr, dmw; logic [31:0] dma, dmd;
    logic mv; logic [31:0] mrd;
    logic en, we; logic [31:0] ma, md;
    logic ifrdy; logic [31:0] ifd;
    logic dmrdy; logic [31:0] dmo;
    logic sf, sm, err;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0, n_bad = 0;
  vec_t tbl [38];
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef MEM_ARB_PERF_EN
  logic [31:0] cnt_conflict, cnt_if_wait, cnt_dm_wait;
`endif
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .cnt_conflict (cnt_conflict),
    .cnt_if_wait  (cnt_if_wait),
    .cnt_dm_wait  (cnt_dm_wait)
`endif
  );
  always #5 clk = ~clk;
  function automatic vec_t v(
    input logic rst_i, ifr, input logic [31:0] ifa,
    input logic dmr, dmw, input logic [31:0] dma, dmd,
    input logic mv, input logic [31:0] mrd,
    input logic en, we, input logic [31:0] ma, md,
    input logic ifrdy, input logic [31:0] ifd,
    input logic dmrdy, input logic [31:0] dmo,
    input logic sf, sm, err);
    vec_t r;
    r.rst = rst_i; r.ifr = ifr; r.ifa = ifa; r.dmr = dmr; r.dmw = dmw; r.dma = dma; r.dmd = dmd;
    r.mv = mv; r.mrd = mrd; r.en = en; r.we = we; r.ma = ma; r.md = md; r.ifrdy = ifrdy;
    r.ifd = ifd; r.dmrdy = dmrdy; r.dmo = dmo; r.sf = sf; r.sm = sm; r.err = err;
    return r;
  endfunction
  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int issues[$];
    int pend;
    logic [31:0] last_mrd;
    tbl[0]  = v(1,0,0,  0,0,0,0,  0,0,          0,0,0,0,     0,0,  0,0,  0,0,0);
    tbl[1]  = v(1,1,IA, 0,0,0,0,  0,0,          0,0,0,0,     0,0,  0,0,  1,0,0);
    tbl[2]  = v(0,1,IA, 0,0,0,0,  0,0,          0,0,0,0,     0,0,  0,0,  1,0,0);
    tbl[3]  = v(0,1,IA, 0,0,0,0,  0,0,          1,0,IA,0,    0,0,  0,0,  1,0,0);
    tbl[4]  = v(0,1,IA, 0,0,0,0,  1,I1,         0,0,IA,0,    1,I1, 0,0,  0,0,0);
    tbl[5]  = v(0,0,0,  0,0,0,0,  0,0,          0,0,IA,0,    0,I1, 0,0,  0,0,0);
    tbl[6]  = v(0,1,IA2,1,0,DA,0, 0,0,          0,0,IA,0,    0,I1, 0,0,  1,1,0);
    tbl[7]  = v(0,1,IA2,1,0,DA,0, 0,0,          1,0,DA,0,    0,I1, 0,0,  1,1,0);
    tbl[8]  = v(0,1,IA2,1,0,DA,0, 0,0,          0,0,DA,0,    0,I1, 0,0,  1,1,0);
    tbl[9]  = v(0,1,IA2,1,0,DA,0, 0,0,          0,0,DA,0,    0,I1, 0,0,  1,1,0);
    tbl[10] = v(0,1,IA2,1,0,DA,0, 1,D1,         0,0,DA,0,    0,I1, 1,D1, 1,0,0);
    tbl[11] = v(0,1,IA2,0,0,0,0,  0,0,          0,0,DA,0,    0,I1, 0,D1, 1,0,0);
    tbl[12] = v(0,1,IA2,0,0,0,0,  0,0,          1,0,IA2,0,   0,I1, 0,D1, 1,0,0);
    tbl[13] = v(0,1,IA2,0,0,0,0,  1,I2,         0,0,IA2,0,   1,I2, 0,D1, 0,0,0);
    tbl[14] = v(0,0,0,  0,0,0,0,  0,0,          0,0,IA2,0,   0,I2, 0,D1, 0,0,0);
    tbl[15] = v(0,0,0,  1,1,SA,DB,0,0,          0,0,IA2,0,   0,I2, 0,D1, 0,1,0);
    tbl[16] = v(0,0,0,  1,1,SA,DB,0,0,          1,1,SA,DB,   0,I2, 0,D1, 0,1,0);
    tbl[17] = v(0,0,0,  1,1,SA,DB,1,32'hCAFEF00D,0,1,SA,DB,  0,I2, 1,D1, 0,0,0);
    tbl[18] = v(0,0,0,  0,0,0,0,  0,0,          0,1,SA,DB,   0,I2, 0,D1, 0,0,0);
    tbl[19] = v(0,1,IA3,1,0,DA4,0,0,0,          0,1,SA,DB,   0,I2, 0,D1, 1,1,0);
    tbl[20] = v(0,1,IA3,1,0,DA4,0,0,0,          1,0,DA4,0,   0,I2, 0,D1, 1,1,0);
    tbl[21] = v(0,1,IA3,1,0,DA4,0,1,D2,         0,0,DA4,0,   0,I2, 1,D2, 1,0,0);
    tbl[22] = v(0,1,IA3,1,0,DA5,0,0,0,          0,0,DA4,0,   0,I2, 0,D2, 1,1,0);
    tbl[23] = v(0,1,IA3,1,0,DA5,0,0,0,          1,0,DA5,0,   0,I2, 0,D2, 1,1,0);
    tbl[24] = v(0,1,IA3,1,0,DA5,0,1,D3,         0,0,DA5,0,   0,I2, 1,D3, 1,0,0);
    tbl[25] = v(0,1,IA3,0,0,0,0,  0,0,          0,0,DA5,0,   0,I2, 0,D3, 1,0,0);
    tbl[26] = v(0,1,IA3,0,0,0,0,  0,0,          1,0,IA3,0,   0,I2, 0,D3, 1,0,0);
    tbl[27] = v(0,1,IA3,0,0,0,0,  1,I3,         0,0,IA3,0,   1,I3, 0,D3, 0,0,0);
    tbl[28] = v(0,0,0,  0,0,0,0,  0,0,          0,0,IA3,0,   0,I3, 0,D3, 0,0,0);
    tbl[29] = v(0,0,0,  0,0,0,0,  1,32'h55555555,0,0,IA3,0,  0,I3, 0,D3, 0,0,0);
    tbl[30] = v(0,0,0,  0,0,0,0,  0,0,          0,0,IA3,0,   0,I3, 0,D3, 0,0,1);
    tbl[31] = v(0,0,0,  0,0,0,0,  0,0,          0,0,IA3,0,   0,I3, 0,D3, 0,0,1);
    tbl[32] = v(0,0,0,  1,0,DA,0, 0,0,          0,0,IA3,0,   0,I3, 0,D3, 0,1,1);
    tbl[33] = v(0,0,0,  1,0,DA,0, 0,0,          1,0,DA,0,    0,I3, 0,D3, 0,1,1);
    tbl[34] = v(1,0,0,  1,0,DA,0, 1,32'h77777777,0,0,DA,0,   0,I3, 0,D3, 0,1,1);
    tbl[35] = v(0,0,0,  0,0,0,0,  0,0,          0,0,0,0,     0,0,  0,0,  0,0,0);
    tbl[36] = v(0,0,0,  0,0,0,0,  1,32'h99,     0,0,0,0,     0,0,  0,0,  0,0,0);
    tbl[37] = v(0,0,0,  0,0,0,0,  0,0,          0,0,0,0,     0,0,  0,0,  0,0,1);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      bus.if_req = tbl[i].ifr; bus.if_addr = tbl[i].ifa;
      bus.dm_req = tbl[i].dmr; bus.dm_we = tbl[i].dmw;
      bus.dm_addr = tbl[i].dma; bus.dm_wdata = tbl[i].dmd;
      bus.mem_valid = tbl[i].mv; bus.mem_rdata = tbl[i].mrd;
      #1;
      check($sformatf("vec%0d", i),
        {25'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready, bus.if_rdata,
         bus.dm_ready, bus.dm_rdata, bus.stall_f, bus.stall_m, bus.err_spurious},
        {25'd0, tbl[i].en, tbl[i].we, tbl[i].ma, tbl[i].md, tbl[i].ifrdy, tbl[i].ifd,
         tbl[i].dmrdy, tbl[i].dmo, tbl[i].sf, tbl[i].sm, tbl[i].err});
`ifdef MEM_ARB_PERF_EN
      if (i == 28) begin
        check("cnt_conflict", {128'd0, cnt_conflict}, 160'd3);
        check("cnt_if_wait", {128'd0, cnt_if_wait}, 160'd17);
        check("cnt_dm_wait", {128'd0, cnt_dm_wait}, 160'd10);
      end
`endif
    end
    // fetch request held with a latency-2 memory: issues must be L+2 = 4 cycles apart
    pend = -1;
    last_mrd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0100;
      bus.mem_valid = (pend == 1);
      last_mrd = 32'h0BAD_0000 + c;
      bus.mem_rdata = last_mrd;
      #1;
      if (pend == 1) begin
        check($sformatf("held_ready_c%0d", c), {126'd0, bus.if_ready, bus.stall_f, bus.if_rdata},
              {126'd0, 1'b1, 1'b0, last_mrd});
        pend = -1;
      end else if (bus.mem_en) begin
        issues.push_back(c);
        pend = 0;
      end else if (pend >= 0) pend++;
    end
    check("held_issue_count", {128'd0, 32'(issues.size())}, 160'd5);
    if (issues.size() >= 2)
      check("held_issue_period", {128'd0, 32'(issues[1] - issues[0])}, 160'd4);
    else begin
      n_vec++; n_bad++;
      $display("FAIL held_issue_period got=%0d issues exp=2 or more", issues.size());
    end
    @(negedge clk);
    bus.if_req = 1'b0; bus.mem_valid = 1'b0;
    #1;
    check("dropped_stall", {158'd0, bus.stall_f, bus.if_ready}, 160'd0);
    @(negedge clk);
    #1;
    check("dropped_no_issue", {159'd0, bus.mem_en}, 160'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the 5-stage pipeline. Arbitrates with fixed data-side priority and issues one memory transaction at a time. Waits for the variable-latency completion, then returns data and a one-cycle ready pulse to the winner. Its stall outputs feed the hazard unit, which stalls or flushes the pipeline accordingly.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetch data; valid with if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid with dm_ready
- dm_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  one-cycle transaction issue strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_valid
- mem_valid  in  1  exactly one pulse per mem_en, at least 1 cycle after it; also acknowledges writes
- stall_f  out  1  to hazard unit: fetch is waiting
- stall_m  out  1  to hazard unit: memory stage is waiting
- err_spurious  out  1  sticky: mem_valid arrived with no transaction outstanding

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- IDLE:
  - If dm_req: drive mem_en=1 with the dm_* fields for one cycle, then go to BUSY_D.
  - Else if if_req: drive mem_en=1, mem_we=0, mem_addr=if_addr, then go to BUSY_I.
  - Else stay in IDLE.
- DM always wins a same-cycle conflict because it holds the older instruction.
- BUSY_x:
  - mem_en is 0.
  - Wait for mem_valid. In that cycle, x_ready=1 combinationally and x_rdata=mem_rdata.
  - mem_rdata is also latched into a per-port hold register; x_rdata shows the hold value in all other cycles.
  - Next state is IDLE.
- mem_addr, mem_we and mem_wdata are registered at issue and held until completion.
- There is no issue in the completion cycle. A requester sampled high in that cycle would be a stale request; it drops or re-presents its request in the following cycle.
- stall_f = if_req & ~if_ready; stall_m = dm_req & ~dm_ready. Both are combinational.
- A mem_valid pulse while in IDLE sets err_spurious and is otherwise ignored; no ready pulse is generated.
- Requests not granted stay pending indefinitely. No timeout.

## Timing
- Reset values:
  - state = IDLE.
  - mem_en, mem_we, if_ready, dm_ready and err_spurious = 0.
  - mem_addr, mem_wdata and both rdata hold registers = 0.
  - stall_f and stall_m follow their equations.
- Memory latency L ≥ 1 (mem_en at cycle T, mem_valid at T+L):
  - Grant/issue in the cycle after the request is first seen high in IDLE, i.e. mem_en is registered.
  - Ready at T+L.
  - Minimum period between issues is L+2 cycles.
- A request rising in the same cycle the other port completes is arbitrated in the next IDLE cycle.
- Reset mid-transaction: return to IDLE and drop the outstanding transaction. The memory shares this reset, so no late mem_valid is expected; if one arrives it sets err_spurious.
- Reset takes priority over mem_valid in the same cycle; no ready pulse is produced.

## Configuration
- MEM_ARB_PERF_EN defined: adds output ports cnt_conflict, cnt_if_wait and cnt_dm_wait, each 32-bit.
  - cnt_conflict increments on IDLE cycles with if_req & dm_req.
  - cnt_if_wait and cnt_dm_wait increment on cycles where stall_f or stall_m is 1, respectively.
  - All counters wrap modulo 2^32 and clear on reset.
- MEM_ARB_PERF_EN undefined: none of these ports or logic exist; behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - the state encoding, arb_state_t (IDLE=0, BUSY_I=1, BUSY_D=2);
  - the ADDR_W and DATA_W defaults.
- Sub-module mem_arb_perf holds the three counters. It is instantiated only under MEM_ARB_PERF_EN.

## Test plan
- IF-only load, L=1: if_req with if_addr=0x00400000 and mem returning 0x8C080004 → mem_en at T, if_ready and if_rdata=0x8C080004 at T+1, stall_f=1 from request until the pulse.
- Conflict, L=3: if_req and dm_req (load, dm_addr=0x10010000) rise together → DM issued first, dm_ready 3 cycles after issue, IF issued 2 cycles after dm_ready; cnt_conflict=1 under the macro.
- Store: dm_we=1, dm_addr=0x10010008, dm_wdata=0xDEADBEEF → one mem_en cycle with mem_we=1 and matching address and data, dm_ready on the ack, dm_rdata unchanged.
- Back-to-back loads with if_req held: IF is granted only in an IDLE cycle without dm_req; stall_f stays 1 the whole time.
- Reset asserted in BUSY_D → next cycle IDLE, no dm_ready pulse, all outputs at their reset values.
- mem_valid pulse while IDLE → err_spurious=1 and stays 1 until reset; no ready pulse.
